// File: rtl/time_pkg.sv
// Shared definitions for the time_keeper block: mode encodings, moduli and
// the active-low 7-segment pattern table.
package time_pkg;

  localparam int unsigned SEC_MOD = 60;
  localparam int unsigned MIN_MOD = 60;

  // Mode / FSM state encodings (2'd3 is illegal)
  localparam logic [1:0] MODE_RUN    = 2'd0;
  localparam logic [1:0] MODE_SET_HH = 2'd1;
  localparam logic [1:0] MODE_SET_MM = 2'd2;

  // Segment patterns {g,f,e,d,c,b,a}, active-low (common anode)
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter modulo MOD.
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   clr_i    synchronous clear to 00 (wins over inc_i)
//   inc_i    increment enable
//   val_o    {tens,units} BCD value (registered)
//   carry_c  combinational carry: inc_i while value is MOD-1
module bcd_mod_counter #(
  parameter int unsigned MOD = 60
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] val_o,
  output logic       carry_c
);

  localparam int unsigned TOP_T = (MOD - 1) / 10;
  localparam int unsigned TOP_U = (MOD - 1) % 10;
  localparam logic [7:0]  TOP   = {4'(TOP_T), 4'(TOP_U)};

  logic [7:0] val_q, val_d;
  logic       at_top;

  assign at_top  = (val_q == TOP);
  assign carry_c = inc_i & at_top & ~clr_i;
  assign val_o   = val_q;

  // Next value: wrap at MOD-1, otherwise BCD increment with units rollover
  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = 8'h00;
    end else if (inc_i) begin
      if (at_top) begin
        val_d = 8'h00;
      end else if (val_q[3:0] == 4'd9) begin
        val_d = {val_q[7:4] + 4'd1, 4'd0};
      end else begin
        val_d = {val_q[7:4], val_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) val_q <= 8'h00;
    else         val_q <= val_d;
  end

endmodule

// File: rtl/time_keeper.sv
// BCD HH:MM:SS timekeeping core with time-set FSM and 6-digit multiplexed
// 7-segment driver.
//   CP               system clock
//   CLR_n            synchronous active-low reset
//   one_HZ           1 Hz square wave (rising edge = one second)
//   five_hundred_HZ  scan-rate square wave (rising edge = next digit)
//   mode_key         key level, rising edge = next mode
//   inc_key          key level, rising edge = increment selected field
//   hour_bcd/min_bcd/sec_bcd  BCD time
//   day_pulse        one-cycle pulse on wrap to 00:00:00
//   mode             0=RUN, 1=SET_HH, 2=SET_MM
//   an               active-low digit enables, bit0 = sec units
//   seg              active-low segments {g,f,e,d,c,b,a}
module time_keeper
  import time_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOUR_MOD    = 24
) (
  input  logic       CP,
  input  logic       CLR_n,
  input  logic       one_HZ,
  input  logic       five_hundred_HZ,
  input  logic       mode_key,
  input  logic       inc_key,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       day_pulse,
  output logic [1:0] mode,
  output logic [5:0] an,
  output logic [6:0] seg
);

  // Input bit positions in the synchronizer vector
  localparam int unsigned B_SEC  = 0;
  localparam int unsigned B_SCAN = 1;
  localparam int unsigned B_MODE = 2;
  localparam int unsigned B_INC  = 3;

  logic [3:0] raw;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] edge_q;
  logic [3:0] sync_out;
  logic [3:0] tick;

  assign raw      = {inc_key, mode_key, five_hundred_HZ, one_HZ};
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign tick     = sync_out & ~edge_q;

  // Synchronizer chains plus edge-detect flop
  always_ff @(posedge CP) begin
    if (!CLR_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 4'b0;
      edge_q <= 4'b0;
    end else begin
      sync_q[0] <= raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      edge_q <= sync_out;
    end
  end

  logic sec_tick, scan_tick, mode_tick, inc_tick, one_sync;
  assign sec_tick  = tick[B_SEC];
  assign scan_tick = tick[B_SCAN];
  assign mode_tick = tick[B_MODE];
  assign inc_tick  = tick[B_INC];
  assign one_sync  = sync_out[B_SEC];

  // Counters
  logic [1:0] mode_q, mode_d;
  logic       sec_inc, min_inc, hour_inc, sec_clr;
  logic       sec_carry, min_carry, hour_carry;
  logic [7:0] sec_val, min_val, hour_val;

  bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk_i(CP), .rst_ni(CLR_n), .clr_i(sec_clr), .inc_i(sec_inc),
    .val_o(sec_val), .carry_c(sec_carry)
  );

  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk_i(CP), .rst_ni(CLR_n), .clr_i(1'b0), .inc_i(min_inc),
    .val_o(min_val), .carry_c(min_carry)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .clk_i(CP), .rst_ni(CLR_n), .clr_i(1'b0), .inc_i(hour_inc),
    .val_o(hour_val), .carry_c(hour_carry)
  );

  // Mode FSM and counter enables; carries only propagate in RUN
  always_comb begin
    mode_d   = mode_q;
    sec_inc  = 1'b0;
    min_inc  = 1'b0;
    hour_inc = 1'b0;
    sec_clr  = 1'b0;
    case (mode_q)
      MODE_RUN: begin
        sec_inc  = sec_tick;
        min_inc  = sec_carry;
        hour_inc = min_carry;
        if (mode_tick) mode_d = MODE_SET_HH;
      end
      MODE_SET_HH: begin
        hour_inc = inc_tick;
        if (mode_tick) mode_d = MODE_SET_MM;
      end
      MODE_SET_MM: begin
        min_inc = inc_tick;
        if (mode_tick) begin
          mode_d  = MODE_RUN;
          sec_clr = 1'b1;
        end
      end
      default: mode_d = MODE_RUN;
    endcase
  end

  always_ff @(posedge CP) begin
    if (!CLR_n) mode_q <= MODE_RUN;
    else        mode_q <= mode_d;
  end

  // Scan index and display mux, registered from the next index so an/seg move together
  logic [2:0] scan_q, scan_d;
  logic [5:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       day_q, day_d;
  logic [3:0] digit;
  logic       blank;

  always_comb begin
    scan_d = scan_q;
    if (scan_tick) scan_d = (scan_q == 3'd5) ? 3'd0 : scan_q + 3'd1;

    an_d = ~(6'b000001 << scan_d);

    case (scan_d)
      3'd0:    digit = sec_val[3:0];
      3'd1:    digit = sec_val[7:4];
      3'd2:    digit = min_val[3:0];
      3'd3:    digit = min_val[7:4];
      3'd4:    digit = hour_val[3:0];
      3'd5:    digit = hour_val[7:4];
      default: digit = sec_val[3:0];
    endcase

    // Field under edit blinks off during the low half of the 1 Hz wave
    blank = 1'b0;
    if (!one_sync) begin
      if (mode_q == MODE_SET_HH && (scan_d == 3'd4 || scan_d == 3'd5)) blank = 1'b1;
      if (mode_q == MODE_SET_MM && (scan_d == 3'd2 || scan_d == 3'd3)) blank = 1'b1;
    end

    seg_d = blank ? SEG_BLANK : seg7(digit);
    day_d = (mode_q == MODE_RUN) & hour_carry;
  end

  always_ff @(posedge CP) begin
    if (!CLR_n) begin
      scan_q <= 3'd0;
      an_q   <= 6'b111110;
      seg_q  <= 7'b1000000;
      day_q  <= 1'b0;
    end else begin
      scan_q <= scan_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      day_q  <= day_d;
    end
  end

  assign hour_bcd  = hour_val;
  assign min_bcd   = min_val;
  assign sec_bcd   = sec_val;
  assign day_pulse = day_q;
  assign mode      = mode_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper (SYNC_STAGES=2, HOUR_MOD=24).
module tb_time_keeper;

  logic       CP = 1'b0;
  logic       CLR_n;
  logic       one_HZ, five_hundred_HZ, mode_key, inc_key;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic       day_pulse;
  logic [1:0] mode;
  logic [5:0] an;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;

  time_keeper #(.SYNC_STAGES(2), .HOUR_MOD(24)) dut (
    .CP(CP), .CLR_n(CLR_n), .one_HZ(one_HZ), .five_hundred_HZ(five_hundred_HZ),
    .mode_key(mode_key), .inc_key(inc_key),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .day_pulse(day_pulse), .mode(mode), .an(an), .seg(seg)
  );

  always #5 CP = ~CP;

  localparam logic [3:0] P_SEC  = 4'b0001;
  localparam logic [3:0] P_SCAN = 4'b0010;
  localparam logic [3:0] P_MODE = 4'b0100;
  localparam logic [3:0] P_INC  = 4'b1000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge CP);
    #1;
  endtask

  // Raise the selected inputs together, hold, then drop them
  task automatic pulse(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      one_HZ          = m[0];
      five_hundred_HZ = m[1];
      mode_key        = m[2];
      inc_key         = m[3];
      cyc(4);
      one_HZ = 1'b0; five_hundred_HZ = 1'b0; mode_key = 1'b0; inc_key = 1'b0;
      cyc(4);
    end
  endtask

  task automatic do_reset();
    CLR_n = 1'b0;
    cyc(2);
    CLR_n = 1'b1;
  endtask

  initial begin
    int hi_cnt;
    logic [23:0] at_pulse;
    CLR_n = 1'b0; one_HZ = 1'b0; five_hundred_HZ = 1'b0; mode_key = 1'b0; inc_key = 1'b0;
    at_pulse = 24'hFFFFFF;
    do_reset();

    // Reset state
    check_eq("rst_time", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);
    check_eq("rst_mode", mode, 2'd0);
    check_eq("rst_an", an, 6'b111110);
    check_eq("rst_seg", seg, 7'b1000000);
    check_eq("rst_day", day_pulse, 1'b0);

    // 1: seconds count and carry into minutes
    pulse(P_SEC, 59);
    check_eq("t1_sec59", sec_bcd, 8'h59);
    check_eq("t1_min00", min_bcd, 8'h00);
    pulse(P_SEC, 1);
    check_eq("t1_sec00", sec_bcd, 8'h00);
    check_eq("t1_min01", min_bcd, 8'h01);

    // 2: preload 23:59:59 and roll the day
    pulse(P_MODE, 1);
    pulse(P_INC, 23);
    pulse(P_MODE, 1);
    pulse(P_INC, 58);
    pulse(P_MODE, 1);
    pulse(P_SEC, 59);
    check_eq("t2_pre", {hour_bcd, min_bcd, sec_bcd}, 24'h235959);
    check_eq("t2_pre_mode", mode, 2'd0);
    hi_cnt = 0;
    one_HZ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (day_pulse) begin
        hi_cnt++;
        at_pulse = {hour_bcd, min_bcd, sec_bcd};
      end
    end
    one_HZ = 1'b0;
    cyc(4);
    check_eq("t2_day_width", hi_cnt, 1);
    check_eq("t2_time_at_day", at_pulse, 24'h000000);
    check_eq("t2_after", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);

    // 3: set mode; seconds frozen; same-cycle mode+inc applies to current field
    pulse(P_SEC, 3);
    check_eq("t3_sec03", sec_bcd, 8'h03);
    pulse(P_MODE, 1);
    check_eq("t3_mode1", mode, 2'd1);
    pulse(P_INC, 4);
    pulse(P_SEC, 2);
    check_eq("t3_frozen", sec_bcd, 8'h03);
    pulse(P_MODE | P_INC, 1);
    check_eq("t3_hour05", hour_bcd, 8'h05);
    check_eq("t3_mode2", mode, 2'd2);
    pulse(P_INC, 61);
    check_eq("t3_min01", min_bcd, 8'h01);
    check_eq("t3_hour_kept", hour_bcd, 8'h05);
    pulse(P_MODE, 1);
    check_eq("t3_mode0", mode, 2'd0);
    check_eq("t3_sec_clr", sec_bcd, 8'h00);

    // 4: scan sequence with 12:34:56 displayed
    do_reset();
    pulse(P_MODE, 1);
    pulse(P_INC, 12);
    pulse(P_MODE, 1);
    pulse(P_INC, 34);
    pulse(P_MODE, 1);
    pulse(P_SEC, 56);
    check_eq("t4_time", {hour_bcd, min_bcd, sec_bcd}, 24'h123456);
    pulse(P_SCAN, 1); check_eq("t4_an1", an, 6'b111101);
    check_eq("t4_seg_sec_tens", seg, 7'b0010010);
    pulse(P_SCAN, 1); check_eq("t4_an2", an, 6'b111011);
    pulse(P_SCAN, 1); check_eq("t4_an3", an, 6'b110111);
    check_eq("t4_seg_min_tens", seg, 7'b0110000);
    pulse(P_SCAN, 1); check_eq("t4_an4", an, 6'b101111);
    pulse(P_SCAN, 1); check_eq("t4_an5", an, 6'b011111);
    check_eq("t4_seg_hour_tens", seg, 7'b1111001);
    pulse(P_SCAN, 1); check_eq("t4_an0", an, 6'b111110);
    check_eq("t4_seg_sec_units", seg, 7'b0000010);
    pulse(P_SCAN, 1); check_eq("t4_an1b", an, 6'b111101);

    // Blink: hour digits blank while synchronized one_HZ is low in SET_HH
    pulse(P_MODE, 1);
    pulse(P_SCAN, 4);
    check_eq("t4_blink_an", an, 6'b011111);
    check_eq("t4_blink_off", seg, 7'b1111111);
    one_HZ = 1'b1;
    cyc(4);
    check_eq("t4_blink_on", seg, 7'b1111001);
    one_HZ = 1'b0;
    cyc(4);
    check_eq("t4_blink_off2", seg, 7'b1111111);
    pulse(P_MODE, 2);
    check_eq("t4_back_run", {hour_bcd, min_bcd, sec_bcd}, 24'h123400);

    // 5: same-cycle sec_tick and mode_tick in RUN
    pulse(P_SEC | P_MODE, 1);
    check_eq("t5_sec01", sec_bcd, 8'h01);
    check_eq("t5_mode1", mode, 2'd1);
    pulse(P_MODE, 2);
    check_eq("t5_sec_clr", sec_bcd, 8'h00);
    one_HZ = 1'b1;
    cyc(25);
    check_eq("t5_hold_one", sec_bcd, 8'h01);
    one_HZ = 1'b0;
    cyc(20);
    check_eq("t5_fall_none", sec_bcd, 8'h01);

    // 6: reset in the middle of SET_MM at 07:42:10
    do_reset();
    pulse(P_SEC, 10);
    pulse(P_MODE, 1);
    pulse(P_INC, 7);
    pulse(P_MODE, 1);
    pulse(P_INC, 42);
    pulse(P_SCAN, 2);
    check_eq("t6_pre", {hour_bcd, min_bcd, sec_bcd}, 24'h074210);
    check_eq("t6_pre_mode", mode, 2'd2);
    CLR_n = 1'b0;
    cyc(1);
    CLR_n = 1'b1;
    check_eq("t6_time", {hour_bcd, min_bcd, sec_bcd}, 24'h000000);
    check_eq("t6_mode", mode, 2'd0);
    check_eq("t6_an", an, 6'b111110);
    check_eq("t6_seg", seg, 7'b1000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
